// File: rtl/hazard_scoreboard.sv
// Issue/stall decision unit between IF/ID and execute: tracks in-flight destination registers,
// inserts bubbles on RAW hazards (or forwards when enabled) and counts stalled cycles.
module hazard_scoreboard #(
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned FORWARD_EN  = 0,
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned AW          = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_in,
  input  logic             instr_valid,
  input  logic             flush,
  output logic [31:0]      instr_out,
  output logic             instr_out_valid,
  output logic             stall,
  output logic [AW-1:0]    fwd_rs1_sel,
  output logic [AW-1:0]    fwd_rs2_sel,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpS     = 7'b0100011;
  localparam logic [6:0] OpB     = 7'b1100011;
  localparam logic [6:0] OpLoad  = 7'b0000011;

  // History entry k holds the instruction issued k+1 cycles ago.
  logic [DEPTH-1:0]      hv_q, hv_d, hl_q, hl_d;
  logic [DEPTH-1:0][4:0] hrd_q, hrd_d;

  logic [31:0]      instr_q, instr_d;
  logic             vld_q, vld_d;
  logic [AW-1:0]    sel1_q, sel1_d, sel2_q, sel2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [6:0]       opcode;
  logic [4:0]       rs1, rs2, rd;
  logic             uses_rs1, uses_rs2, writes_rd, is_load;
  logic [DEPTH-1:0] m1, m2, hv_m;
  logic             hazard_raw, hazard, issue;
  logic [AW-1:0]    sel1, sel2;

  always_comb begin
    opcode    = instr_in[6:0];
    rs1       = instr_in[19:15];
    rs2       = instr_in[24:20];
    rd        = instr_in[11:7];
    uses_rs1  = !(opcode == OpLui || opcode == OpAuipc || opcode == OpJal);
    uses_rs2  = (opcode == OpR || opcode == OpS || opcode == OpB);
    writes_rd = !(opcode == OpS || opcode == OpB) && (rd != 5'd0);
    is_load   = (opcode == OpLoad);
  end

  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      m1[k] = hv_q[k] && uses_rs1 && (hrd_q[k] == rs1) && (hrd_q[k] != 5'd0);
      m2[k] = hv_q[k] && uses_rs2 && (hrd_q[k] == rs2) && (hrd_q[k] != 5'd0);
    end
    // Scanning oldest to youngest lets the youngest producer win.
    sel1 = '0;
    sel2 = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (m1[k]) sel1 = AW'(k + 1);
      if (m2[k]) sel2 = AW'(k + 1);
    end
    if (FORWARD_EN != 0) hazard_raw = (m1[0] || m2[0]) && hl_q[0];
    else                 hazard_raw = |{m1, m2};
    hazard = instr_valid && !flush && hazard_raw;
    issue  = instr_valid && !flush && !hazard;
  end

  assign stall = hazard;

  always_comb begin
    hv_m = hv_q;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (flush && k < int'(FLUSH_DEPTH)) hv_m[k] = 1'b0;
    end
    hv_d  = '0;
    hl_d  = '0;
    hrd_d = '0;
    for (int k = 1; k < int'(DEPTH); k++) begin
      hv_d[k]  = hv_m[k-1];
      hl_d[k]  = hl_q[k-1];
      hrd_d[k] = hrd_q[k-1];
    end
    hv_d[0]  = issue && writes_rd;
    hl_d[0]  = issue && is_load;
    hrd_d[0] = issue ? rd : 5'd0;

    instr_d = issue ? instr_in : NOP_INSTR;
    vld_d   = issue;
    sel1_d  = (issue && FORWARD_EN != 0) ? sel1 : '0;
    sel2_d  = (issue && FORWARD_EN != 0) ? sel2 : '0;
    cnt_d   = (stall && cnt_q != {CNT_W{1'b1}}) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hv_q    <= '0;
      hl_q    <= '0;
      hrd_q   <= '0;
      instr_q <= NOP_INSTR;
      vld_q   <= 1'b0;
      sel1_q  <= '0;
      sel2_q  <= '0;
      cnt_q   <= '0;
    end else begin
      hv_q    <= hv_d;
      hl_q    <= hl_d;
      hrd_q   <= hrd_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      sel1_q  <= sel1_d;
      sel2_q  <= sel2_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_out       = instr_q;
  assign instr_out_valid = vld_q;
  assign fwd_rs1_sel     = sel1_q;
  assign fwd_rs2_sel     = sel2_q;
  assign stall_count     = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: stall-only, forwarding and 2-bit-counter instances
// share one stimulus stream; expectations are queued when driven and popped after each edge.
module tb_hazard_scoreboard;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] I_A     = 32'h0020_82B3; // add x5,x1,x2
  localparam logic [31:0] I_B     = 32'h0032_8333; // add x6,x5,x3
  localparam logic [31:0] I_BB    = 32'h0052_8333; // add x6,x5,x5
  localparam logic [31:0] I_LW    = 32'h0000_A283; // lw x5,0(x1)
  localparam logic [31:0] I_ADDI0 = 32'h0010_0013; // addi x0,x0,1
  localparam logic [31:0] I_ADDX0 = 32'h0000_00B3; // add x1,x0,x0
  localparam logic [31:0] I_LUI7  = 32'h1234_53B7; // lui x7,0x12345
  localparam logic [31:0] I_LUI8  = 32'h0003_8437; // lui x8, imm[19:15]=7
  localparam logic [31:0] I_SW    = 32'h0070_A023; // sw x7,0(x1)

  typedef struct packed {
    logic [31:0] instr;
    logic        vld;
    logic        fl;
  } stim_t;

  typedef struct packed {
    logic        stall;
    logic [31:0] instr;
    logic        vld;
    logic [1:0]  s1;
    logic [1:0]  s2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_in = NOP;
  logic        instr_valid = 1'b0;
  logic        flush = 1'b0;

  logic [31:0] d0_out, d1_out, d2_out;
  logic        d0_vld, d1_vld, d2_vld, d0_st, d1_st, d2_st;
  logic [1:0]  d0_s1, d0_s2, d1_s1, d1_s2, d2_s1, d2_s2;
  logic [15:0] d0_cnt, d1_cnt;
  logic [1:0]  d2_cnt;

  int          sel_dut = 0;
  logic        obs_stall;
  logic [36:0] obs_out;
  int          errors = 0;
  int          checks = 0;
  stim_t       pl_st[$];
  exp_t        pl_ex[$];
  exp_t        sb_q[$];

  always #5 clk = ~clk;

  hazard_scoreboard #(.DEPTH(2), .FORWARD_EN(0)) u_dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid), .flush(flush),
    .instr_out(d0_out), .instr_out_valid(d0_vld), .stall(d0_st),
    .fwd_rs1_sel(d0_s1), .fwd_rs2_sel(d0_s2), .stall_count(d0_cnt)
  );

  hazard_scoreboard #(.DEPTH(2), .FORWARD_EN(1)) u_fwd (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid), .flush(flush),
    .instr_out(d1_out), .instr_out_valid(d1_vld), .stall(d1_st),
    .fwd_rs1_sel(d1_s1), .fwd_rs2_sel(d1_s2), .stall_count(d1_cnt)
  );

  hazard_scoreboard #(.DEPTH(2), .FORWARD_EN(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid), .flush(flush),
    .instr_out(d2_out), .instr_out_valid(d2_vld), .stall(d2_st),
    .fwd_rs1_sel(d2_s1), .fwd_rs2_sel(d2_s2), .stall_count(d2_cnt)
  );

  always_comb begin
    obs_stall = d0_st;
    obs_out   = {d0_out, d0_vld, d0_s1, d0_s2};
    case (sel_dut)
      1: begin
        obs_stall = d1_st;
        obs_out   = {d1_out, d1_vld, d1_s1, d1_s2};
      end
      2: begin
        obs_stall = d2_st;
        obs_out   = {d2_out, d2_vld, d2_s1, d2_s2};
      end
      default: ;
    endcase
  end

  function automatic stim_t mk_st(logic [31:0] i, logic v, logic f);
    return {i, v, f};
  endfunction

  function automatic exp_t mk_ex(logic st, logic [31:0] i, logic v, logic [1:0] a, logic [1:0] b);
    return {st, i, v, a, b};
  endfunction

  task automatic plan(input stim_t s, input exp_t e);
    pl_st.push_back(s);
    pl_ex.push_back(e);
  endtask

  // Inputs change on the falling edge; stall is sampled 1 time unit later.
  task automatic drive(input stim_t s);
    @(negedge clk);
    instr_in    = s.instr;
    instr_valid = s.vld;
    flush       = s.fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    instr_valid = 1'b0;
    flush       = 1'b0;
    instr_in    = NOP;
    @(negedge clk);
    rst = 1'b0;
    pl_st.delete();
    pl_ex.delete();
    sb_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst         = 1'b1;
    instr_in    = I_B;
    instr_valid = 1'b1;
    tick();
    checks++;
    if ({d0_out, d0_vld, d0_s1, d0_s2, d0_st} !== {NOP, 1'b0, 2'd0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset u_dut outputs: got %h/%b/%0d/%0d/%b want NOP/0/0/0/0",
               d0_out, d0_vld, d0_s1, d0_s2, d0_st);
    end
    checks++;
    if ({d1_out, d1_vld, d1_s1, d1_s2, d1_st} !== {NOP, 1'b0, 2'd0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset u_fwd outputs: got %h/%b/%0d/%0d/%b want NOP/0/0/0/0",
               d1_out, d1_vld, d1_s1, d1_s2, d1_st);
    end
    checks++;
    if ({d0_cnt, d2_cnt} !== 18'd0) begin
      errors++;
      $display("FAIL reset counters: got %0d/%0d want 0/0", d0_cnt, d2_cnt);
    end
    do_reset();
  endtask

  task automatic test_raw_stall();
    stim_t s;
    exp_t  e;
    do_reset();
    sel_dut = 0;
    plan(mk_st(I_A, 1, 0), mk_ex(0, I_A, 1, 0, 0));
    plan(mk_st(I_B, 1, 0), mk_ex(1, NOP, 0, 0, 0));
    plan(mk_st(I_B, 1, 0), mk_ex(1, NOP, 0, 0, 0));
    plan(mk_st(I_B, 1, 0), mk_ex(0, I_B, 1, 0, 0));
    for (int i = 0; pl_st.size() != 0; i++) begin
      s = pl_st.pop_front();
      drive(s);
      sb_q.push_back(pl_ex.pop_front());
      checks++;
      if (obs_stall !== sb_q[0].stall) begin
        errors++;
        $display("FAIL raw_stall stall c%0d: got %b want %b", i, obs_stall, sb_q[0].stall);
      end
      tick();
      e = sb_q.pop_front();
      checks++;
      if (obs_out !== {e.instr, e.vld, e.s1, e.s2}) begin
        errors++;
        $display("FAIL raw_stall out c%0d: got %h want %h", i, obs_out,
                 {e.instr, e.vld, e.s1, e.s2});
      end
    end
    checks++;
    if (d0_cnt !== 16'd2) begin
      errors++;
      $display("FAIL raw_stall count: got %0d want 2", d0_cnt);
    end
  endtask

  task automatic test_forward();
    stim_t s;
    exp_t  e;
    do_reset();
    sel_dut = 1;
    plan(mk_st(I_A, 1, 0),  mk_ex(0, I_A, 1, 0, 0));
    plan(mk_st(I_B, 1, 0),  mk_ex(0, I_B, 1, 1, 0));
    plan(mk_st(NOP, 0, 0),  mk_ex(0, NOP, 0, 0, 0));
    plan(mk_st(I_A, 1, 0),  mk_ex(0, I_A, 1, 0, 0));
    plan(mk_st(I_A, 1, 0),  mk_ex(0, I_A, 1, 0, 0));
    plan(mk_st(I_BB, 1, 0), mk_ex(0, I_BB, 1, 1, 1));
    for (int i = 0; pl_st.size() != 0; i++) begin
      s = pl_st.pop_front();
      drive(s);
      sb_q.push_back(pl_ex.pop_front());
      checks++;
      if (obs_stall !== sb_q[0].stall) begin
        errors++;
        $display("FAIL forward stall c%0d: got %b want %b", i, obs_stall, sb_q[0].stall);
      end
      tick();
      e = sb_q.pop_front();
      checks++;
      if (obs_out !== {e.instr, e.vld, e.s1, e.s2}) begin
        errors++;
        $display("FAIL forward out c%0d: got %h want %h", i, obs_out,
                 {e.instr, e.vld, e.s1, e.s2});
      end
    end
  endtask

  task automatic test_load_use();
    stim_t s;
    exp_t  e;
    do_reset();
    sel_dut = 1;
    plan(mk_st(I_LW, 1, 0), mk_ex(0, I_LW, 1, 0, 0));
    plan(mk_st(I_B, 1, 0),  mk_ex(1, NOP, 0, 0, 0));
    plan(mk_st(I_B, 1, 0),  mk_ex(0, I_B, 1, 2, 0));
    for (int i = 0; pl_st.size() != 0; i++) begin
      s = pl_st.pop_front();
      drive(s);
      sb_q.push_back(pl_ex.pop_front());
      checks++;
      if (obs_stall !== sb_q[0].stall) begin
        errors++;
        $display("FAIL load_use stall c%0d: got %b want %b", i, obs_stall, sb_q[0].stall);
      end
      tick();
      e = sb_q.pop_front();
      checks++;
      if (obs_out !== {e.instr, e.vld, e.s1, e.s2}) begin
        errors++;
        $display("FAIL load_use out c%0d: got %h want %h", i, obs_out,
                 {e.instr, e.vld, e.s1, e.s2});
      end
    end
  endtask

  task automatic test_filter();
    stim_t s;
    exp_t  e;
    do_reset();
    sel_dut = 0;
    plan(mk_st(I_ADDI0, 1, 0), mk_ex(0, I_ADDI0, 1, 0, 0));
    plan(mk_st(I_ADDX0, 1, 0), mk_ex(0, I_ADDX0, 1, 0, 0));
    plan(mk_st(I_LUI7, 1, 0),  mk_ex(0, I_LUI7, 1, 0, 0));
    plan(mk_st(I_LUI8, 1, 0),  mk_ex(0, I_LUI8, 1, 0, 0));
    plan(mk_st(I_SW, 1, 0),    mk_ex(1, NOP, 0, 0, 0));
    plan(mk_st(I_SW, 1, 0),    mk_ex(0, I_SW, 1, 0, 0));
    for (int i = 0; pl_st.size() != 0; i++) begin
      s = pl_st.pop_front();
      drive(s);
      sb_q.push_back(pl_ex.pop_front());
      checks++;
      if (obs_stall !== sb_q[0].stall) begin
        errors++;
        $display("FAIL filter stall c%0d: got %b want %b", i, obs_stall, sb_q[0].stall);
      end
      tick();
      e = sb_q.pop_front();
      checks++;
      if (obs_out !== {e.instr, e.vld, e.s1, e.s2}) begin
        errors++;
        $display("FAIL filter out c%0d: got %h want %h", i, obs_out,
                 {e.instr, e.vld, e.s1, e.s2});
      end
    end
  endtask

  task automatic test_flush();
    stim_t s;
    exp_t  e;
    do_reset();
    sel_dut = 0;
    plan(mk_st(I_A, 1, 0), mk_ex(0, I_A, 1, 0, 0));
    plan(mk_st(I_B, 1, 1), mk_ex(0, NOP, 0, 0, 0));
    plan(mk_st(I_B, 1, 0), mk_ex(0, I_B, 1, 0, 0));
    for (int i = 0; pl_st.size() != 0; i++) begin
      s = pl_st.pop_front();
      drive(s);
      sb_q.push_back(pl_ex.pop_front());
      checks++;
      if (obs_stall !== sb_q[0].stall) begin
        errors++;
        $display("FAIL flush stall c%0d: got %b want %b", i, obs_stall, sb_q[0].stall);
      end
      tick();
      e = sb_q.pop_front();
      checks++;
      if (obs_out !== {e.instr, e.vld, e.s1, e.s2}) begin
        errors++;
        $display("FAIL flush out c%0d: got %h want %h", i, obs_out,
                 {e.instr, e.vld, e.s1, e.s2});
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(mk_st(I_A, 1, 0));
    tick();
    drive(mk_st(I_B, 1, 0));
    tick();
    drive(mk_st(I_B, 1, 0));
    checks++;
    if (d0_st !== 1'b1 || d0_cnt !== 16'd1) begin
      errors++;
      $display("FAIL mid_reset pre: got stall=%b cnt=%0d want 1/1", d0_st, d0_cnt);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (d0_st !== 1'b0 || d0_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset u_dut: got stall=%b cnt=%0d want 0/0", d0_st, d0_cnt);
    end
    checks++;
    if ({d1_out, d1_vld, d1_s1} !== {NOP, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL mid_reset u_fwd: got %h/%b/%0d want NOP/0/0", d1_out, d1_vld, d1_s1);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (d0_st !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset empty history stall: got %b want 0", d0_st);
    end
    tick();
    checks++;
    if ({d0_out, d0_vld} !== {I_B, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset first issue: got %h/%b want %h/1", d0_out, d0_vld, I_B);
    end
  endtask

  task automatic test_saturation();
    stim_t s;
    exp_t  e;
    do_reset();
    sel_dut = 2;
    for (int r = 0; r < 2; r++) begin
      plan(mk_st(I_A, 1, 0), mk_ex(0, I_A, 1, 0, 0));
      plan(mk_st(I_B, 1, 0), mk_ex(1, NOP, 0, 0, 0));
      plan(mk_st(I_B, 1, 0), mk_ex(1, NOP, 0, 0, 0));
      plan(mk_st(I_B, 1, 0), mk_ex(0, I_B, 1, 0, 0));
    end
    plan(mk_st(I_A, 1, 0), mk_ex(0, I_A, 1, 0, 0));
    plan(mk_st(I_B, 1, 0), mk_ex(1, NOP, 0, 0, 0));
    for (int i = 0; pl_st.size() != 0; i++) begin
      s = pl_st.pop_front();
      drive(s);
      sb_q.push_back(pl_ex.pop_front());
      checks++;
      if (obs_stall !== sb_q[0].stall) begin
        errors++;
        $display("FAIL saturation stall c%0d: got %b want %b", i, obs_stall, sb_q[0].stall);
      end
      tick();
      e = sb_q.pop_front();
      checks++;
      if (obs_out !== {e.instr, e.vld, e.s1, e.s2}) begin
        errors++;
        $display("FAIL saturation out c%0d: got %h want %h", i, obs_out,
                 {e.instr, e.vld, e.s1, e.s2});
      end
    end
    checks++;
    if (d2_cnt !== 2'd3) begin
      errors++;
      $display("FAIL saturation 2-bit count: got %0d want 3", d2_cnt);
    end
    checks++;
    if (d0_cnt !== 16'd5) begin
      errors++;
      $display("FAIL saturation 16-bit count: got %0d want 5", d0_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_raw_stall();
    test_forward();
    test_load_use();
    test_filter();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised hazard unit sitting between the IF/ID boundary and the execute stage.
- Tracks the destination registers of the last DEPTH issued instructions in an internal history shift register.
- Decides each cycle whether to issue the incoming instruction or insert a bubble, and stalls fetch when it inserts one.
- Optionally resolves hazards by forwarding instead of stalling (load-use still stalls).
- Registers the issued instruction and its forwarding selects, and keeps a saturating stall-cycle counter.

Parameters:
DEPTH, 2, number of in-flight instructions tracked (ages 1..DEPTH); minimum 1
FORWARD_EN, 0, 0 = stall on any RAW match; 1 = forward, stall only on load-use at age 1
FLUSH_DEPTH, 1, number of youngest history entries invalidated on flush; must be <= DEPTH
NOP_INSTR, 32'h00000013, bubble encoding driven on instr_out
CNT_W, 16, stall counter width
AW, $clog2(DEPTH+1), forward-select width (derived; do not override)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset; asynchronous and active-high
instr_in  in  32  instruction from IF/ID
instr_valid  in  1  instr_in carries a real instruction
flush  in  1  squash instr_in and the youngest FLUSH_DEPTH history entries
instr_out  out  32  registered issued instruction or NOP_INSTR
instr_out_valid  out  1  registered; 1 when instr_out is a real instruction
stall  out  1  combinational; hold PC and IF/ID this cycle
fwd_rs1_sel  out  AW  registered; age of the youngest producer of rs1, 0 = register file
fwd_rs2_sel  out  AW  registered; same for rs2
stall_count  out  CNT_W  saturating count of cycles with stall=1

Behaviour:
- Decode of instr_in:
  - rs1 = [19:15], rs2 = [24:20], rd = [11:7], opcode = [6:0].
  - uses_rs1 is false for LUI (0110111), AUIPC (0010111) and JAL (1101111).
  - uses_rs2 is true only for R (0110011), S (0100011) and B (1100011).
  - writes_rd is false for S and B, and false when rd == 0.
  - is_load when opcode == 0000011.
- History entries hold {valid, rd, is_load}; entry k has age k+1.
- A match at age a means: a valid entry at age a, its rd equals a used source, and that rd != 0.
- Hazard (combinational), only when instr_valid=1 and flush=0:
  - FORWARD_EN=0: hazard when any match exists at ages 1..DEPTH.
  - FORWARD_EN=1: hazard only when the age-1 match is a load.
- stall = hazard.
- On each rising edge, with no reset:
  - If flush: clear valid on entries aged 1..FLUSH_DEPTH, then shift; push an invalid entry; instr_out <= NOP_INSTR; instr_out_valid <= 0; fwd selects <= 0.
  - Else if hazard or instr_valid=0: shift history and push an invalid entry (bubble); instr_out <= NOP_INSTR; instr_out_valid <= 0; fwd selects <= 0.
  - Else issue: shift history and push {writes_rd, rd, is_load}; instr_out <= instr_in; instr_out_valid <= 1.
  - On issue with FORWARD_EN=1, fwd_rsX_sel <= the smallest matching age for that source, or 0 if none.
  - On issue with FORWARD_EN=0, fwd selects are always 0.
- Stall latency and duration:
  - stall is asserted in the same cycle the hazard is visible.
  - Each bubble ages the history by one, so stall self-clears when the producer ages past DEPTH (FORWARD_EN=0) or past age 1 (FORWARD_EN=1).
  - Worst case is DEPTH stalled cycles (FORWARD_EN=0) or 1 stalled cycle (FORWARD_EN=1).
- stall_count increments by 1 on each edge where stall=1, and saturates at all-ones without wrapping.
- Simultaneous events:
  - flush overrides hazard; stall is forced to 0 while flush=1.
  - When several ages match, the youngest wins for forwarding.
  - rs1 == rs2 yields identical selects.
- Reset (asynchronous, any time including mid-stall):
  - All history entries invalid; instr_out = NOP_INSTR; instr_out_valid = 0; fwd selects = 0; stall_count = 0.
  - stall therefore reads 0 while rst is high.
  - The first edge after release behaves as if the history is empty.
- With DEPTH=1 the history is a single register; shift degenerates to load.

Test Plan:
- DEPTH=2, FORWARD_EN=0: issue add x5,x1,x2 (0x002082B3), then add x6,x5,x3 (0x00328333) held valid -> stall=1 for exactly 2 cycles, two NOPs on instr_out, third edge issues 0x00328333; stall_count=2.
- FORWARD_EN=1: same pair -> no stall; second issue has fwd_rs1_sel=1, fwd_rs2_sel=0.
- FORWARD_EN=1 load-use: lw x5,0(x1) (0x0000A283), then add x6,x5,x3 -> one stall cycle, one NOP, then issue with fwd_rs1_sel=2.
- Register x0 and opcode filtering: addi x0,... followed by add using x0 -> no stall. sw whose rs2 matches a prior lui rd -> stall. lui followed by an instruction whose [19:15] equals the lui rd but does not use rs1 -> no stall.
- Flush during stall: assert flush in the first stall cycle -> stall=0 that cycle; next instr_out=NOP, instr_out_valid=0; the youngest entry is cleared, so an unrelated next instruction issues immediately.
- Reset mid-stall, plus saturation: pulse rst asynchronously between edges -> outputs go to reset values immediately and the history is empty. With CNT_W=2, force 5 stall cycles -> stall_count holds 3.
